// File: rtl/switch_scan_ctrl.sv
// Switch bank scanner: synchronizes and debounces data_sw on a prescaled tick, tracks changed bits,
// and exposes data/change/control registers. Define SWITCH_IRQ_EN to build the level interrupt.
module switch_scan_ctrl #(
    parameter int          PRESC_DIV   = 50000,
    parameter int          DEB_SAMPLES = 4,
    parameter logic [11:0] BASE_ADDR   = 12'h070
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [11:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [23:0] data_sw,
    output logic [31:0] rdata,
    output logic        irq
);

    // state    | meaning
    // S_WAIT   | idle until the next sample tick
    // S_CMP    | compare the new sample against the running candidate
    // S_COMMIT | copy the stable candidate into deb and flag changed bits

    localparam int          PW         = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);
    localparam logic [3:0]  DEB_N      = 4'(DEB_SAMPLES);
    localparam logic [11:0] ADDR_DATA  = BASE_ADDR;
    localparam logic [11:0] ADDR_CHG   = BASE_ADDR + 12'd4;
    localparam logic [11:0] ADDR_CTRL  = BASE_ADDR + 12'd8;

    typedef enum logic [1:0] {S_WAIT, S_CMP, S_COMMIT} state_t;

    state_t        state, state_nxt;
    logic [23:0]   sw_meta, sw_s, smp, last, deb, chg;
    logic [23:0]   last_upd, chg_nxt;
    logic [3:0]    cnt, cnt_upd;
    logic [PW-1:0] presc;
    logic          en, ie_bit, tick;
    logic          do_latch, do_cmp, do_commit;
    logic          wr_chg, wr_ctrl;

    assign tick    = en && (presc == PRESC_LAST);
    assign wr_chg  = we && (addr == ADDR_CHG);
    assign wr_ctrl = we && (addr == ADDR_CTRL);

    always_comb begin
        cnt_upd  = 4'd1;
        last_upd = smp;
        if (smp == last) begin
            last_upd = last;
            cnt_upd  = (cnt >= DEB_N) ? DEB_N : cnt + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= S_WAIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_latch  = 1'b0;
        do_cmp    = 1'b0;
        do_commit = 1'b0;
        if (!en) begin
            state_nxt = S_WAIT;
        end else begin
            case (state)
                S_WAIT: begin
                    if (tick) begin
                        do_latch  = 1'b1;
                        state_nxt = S_CMP;
                    end
                end
                S_CMP: begin
                    do_cmp    = 1'b1;
                    state_nxt = (cnt_upd == DEB_N && last_upd != deb) ? S_COMMIT : S_WAIT;
                end
                S_COMMIT: begin
                    do_commit = 1'b1;
                    // with a very short prescaler the next tick can land here; do not drop it
                    if (tick) begin
                        do_latch  = 1'b1;
                        state_nxt = S_CMP;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
                default: state_nxt = S_WAIT;
            endcase
        end
    end

    // commit is applied after the clear so a coincident set survives
    always_comb begin
        chg_nxt = chg;
        if (wr_chg)    chg_nxt = chg_nxt & ~wdata[23:0];
        if (do_commit) chg_nxt = chg_nxt | (deb ^ last);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sw_meta <= '0;
            sw_s    <= '0;
            smp     <= '0;
            last    <= '0;
            deb     <= '0;
            chg     <= '0;
            cnt     <= '0;
            presc   <= '0;
            en      <= 1'b1;
            rdata   <= '0;
        end else begin
            sw_meta <= data_sw;
            sw_s    <= sw_meta;

            if (!en || presc == PRESC_LAST) presc <= '0;
            else                            presc <= presc + PW'(1);

            if (do_latch) smp <= sw_s;

            if (!en) begin
                cnt <= '0;
            end else if (do_cmp) begin
                cnt  <= cnt_upd;
                last <= last_upd;
            end

            if (do_commit) deb <= last;
            chg <= chg_nxt;

            if (wr_ctrl) en <= wdata[0];

            case (addr)
                ADDR_DATA: rdata <= {{8{deb[23]}}, deb};
                ADDR_CHG:  rdata <= {8'b0, chg};
                ADDR_CTRL: rdata <= {30'b0, ie_bit, en};
                default:   rdata <= rdata;
            endcase
        end
    end

`ifdef SWITCH_IRQ_EN
    logic ie;
    logic unused_wdata;

    assign ie_bit       = ie;
    assign unused_wdata = ^wdata[31:24];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ie  <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (wr_ctrl) ie <= wdata[1];
            irq <= ie & (|chg);
        end
    end
`else
    logic unused_wdata;

    assign ie_bit       = 1'b0;
    assign irq          = 1'b0;
    assign unused_wdata = ^{wdata[31:24], wdata[1]};
`endif

endmodule

// File: tb/tb_switch_scan_ctrl.sv
// Self-checking bench for switch_scan_ctrl with PRESC_DIV=4, DEB_SAMPLES=3: directed cases
// followed by randomized long holds, short glitches and W1C writes against a vector-level model.
module tb_switch_scan_ctrl;

    localparam int          PD     = 4;
    localparam int          DS     = 3;
    localparam logic [11:0] A_DATA = 12'h070;
    localparam logic [11:0] A_CHG  = 12'h074;
    localparam logic [11:0] A_CTRL = 12'h078;
    localparam logic [11:0] A_NONE = 12'hFFF;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [11:0] addr  = A_NONE;
    logic        we    = 1'b0;
    logic [31:0] wdata = '0;
    logic [23:0] data_sw = '0;
    logic [31:0] rdata;
    logic        irq;

    int errors = 0;
    int checks = 0;

    logic [23:0] m_deb;
    logic [23:0] m_chg;
    logic        m_ie;

    switch_scan_ctrl #(.PRESC_DIV(PD), .DEB_SAMPLES(DS), .BASE_ADDR(12'h070)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .addr   (addr),
        .we     (we),
        .wdata  (wdata),
        .data_sw(data_sw),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] sext(input logic [23:0] d);
        return {{8{d[23]}}, d};
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        we   = 1'b0;
        cyc(1);
        check32(tag, rdata, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        cyc(1);
        we    = 1'b0;
        addr  = A_NONE;
    endtask

    task automatic do_reset(input logic [23:0] d);
        rst_i   = 1'b0;
        data_sw = d;
        we      = 1'b0;
        addr    = A_NONE;
        cyc(3);
        rst_i   = 1'b1;
        m_deb   = '0;
        m_chg   = '0;
        m_ie    = 1'b0;
    endtask

    initial begin
        logic [31:0] first_bad;
        logic [23:0] v;
        logic [31:0] mask;
        int          commit_edge;
        int          found;
        int          op;
        int          len;

        // reset state
        do_reset(24'hFFFFFF);
        rd(A_DATA, 32'h0, "reset_data");
        rd(A_CTRL, 32'h1, "reset_ctrl");
        rd(A_CHG, 32'h0, "reset_chg");
        check32("reset_irq", {31'b0, irq}, 32'h0);

        // steady input with the sign bit set
        do_reset(24'h800001);
        cyc(16);
        rd(A_DATA, 32'hFF800001, "steady_data");
        rd(A_CHG, 32'h00800001, "steady_chg");

        // glitch rejection
        do_reset(24'h0);
        cyc(2);
        data_sw = 24'h000001;
        cyc(5);
        data_sw = 24'h0;
        first_bad = '0;
        for (int i = 0; i < 40; i++) begin
            addr = A_DATA;
            cyc(1);
            if (rdata !== 32'h0 && first_bad === 32'h0) first_bad = rdata;
        end
        check32("glitch_data_hold", first_bad, 32'h0);
        rd(A_CHG, 32'h0, "glitch_chg");

`ifdef SWITCH_IRQ_EN
        do_reset(24'h0);
        wr(A_CTRL, 32'h3);
        data_sw = 24'h000010;
        cyc(20);
        check32("irq_on_commit", {31'b0, irq}, 32'h1);
        wr(A_CHG, 32'h10);
        cyc(1);
        check32("irq_off_after_w1c", {31'b0, irq}, 32'h0);
        rd(A_CHG, 32'h0, "irq_chg_cleared");
`else
        do_reset(24'h0);
        wr(A_CTRL, 32'h3);
        rd(A_CTRL, 32'h1, "ctrl_ie_ignored");
        data_sw = 24'h000010;
        cyc(20);
        check32("irq_tied_low", {31'b0, irq}, 32'h0);
`endif

        // set-wins race: sample n is latched at edge PD*n-1, commit two edges after the DS-th
        commit_edge = PD * DS - 1 + 2;
        for (int k = commit_edge - 2; k <= commit_edge + 2; k++) begin
            do_reset(24'h000010);
            cyc(k);
            wr(A_CHG, 32'h10);
            cyc(6);
            rd(A_CHG, (k <= commit_edge) ? 32'h10 : 32'h0, $sformatf("race_w1c_edge%0d", k));
        end

        // disable freezes deb; re-enable commits the new vector
        do_reset(24'h000010);
        cyc(20);
        wr(A_CTRL, 32'h0);
        data_sw = 24'h00FF00;
        cyc(40);
        rd(A_DATA, 32'h00000010, "disabled_data_frozen");
        rd(A_CTRL, 32'h0, "disabled_ctrl");
        wr(A_CTRL, 32'h1);
        found = 0;
        for (int i = 0; i < 18 && found == 0; i++) begin
            addr = A_DATA;
            cyc(1);
            if (rdata === 32'h0000FF00) found = 1;
        end
        check32("reenable_commit", found, 1);
        rd(A_CHG, 32'h0000FF10, "reenable_chg");

        // randomized long holds, short glitches and W1C writes
        do_reset(24'h0);
        wr(A_CTRL, 32'h3);
`ifdef SWITCH_IRQ_EN
        m_ie = 1'b1;
`endif
        for (int it = 0; it < 30; it++) begin
            op = (it == 0) ? 1 : int'($urandom_range(0, 2));
            if (op == 0) begin
                v   = 24'($urandom);
                len = int'($urandom_range(1, 6));
                data_sw = v;
                cyc(len);
                data_sw = m_deb;
                cyc(8);
                rd(A_DATA, sext(m_deb), $sformatf("rnd%0d_glitch_data", it));
            end else if (op == 1) begin
                v = 24'($urandom);
                data_sw = v;
                cyc(20);
                m_chg = m_chg | (m_deb ^ v);
                m_deb = v;
                rd(A_DATA, sext(m_deb), $sformatf("rnd%0d_hold_data", it));
                rd(A_CHG, {8'b0, m_chg}, $sformatf("rnd%0d_hold_chg", it));
            end else begin
                mask = $urandom;
                wr(A_CHG, mask);
                m_chg = m_chg & ~mask[23:0];
                rd(A_CHG, {8'b0, m_chg}, $sformatf("rnd%0d_w1c_chg", it));
            end
            check32($sformatf("rnd%0d_irq", it), {31'b0, irq}, {31'b0, m_ie & (|m_chg)});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/switch_scan_ctrl.md
Name: switch_scan_ctrl

Overview:
Controller for the on-board 24-bit switch bank on the SoC peripheral bus. Synchronizes and debounces the raw switch vector on a prescaled sample tick, then commits a stable value. It tracks which switches changed and exposes data, change-status and control registers through the 12-bit peripheral address decode. An interrupt to the CPU is available as a build option.

Parameters:
PRESC_DIV, 50000, clk_i cycles per sample tick (≥2); 1 ms at 50 MHz.
DEB_SAMPLES, 4, consecutive identical samples needed to commit (≥2, ≤15).
BASE_ADDR, 12'h070, address of the data register; change status at BASE_ADDR+4, control at BASE_ADDR+8.

Ports:
clk_i  in  1  system clock; all logic on the rising edge.
rst_i  in  1  reset, synchronous, active-low.
addr  in  12  peripheral byte address.
we  in  1  write strobe, one cycle, qualified by addr.
wdata  in  32  write data.
data_sw  in  24  raw asynchronous switch inputs.
rdata  out  32  registered read data.
irq  out  1  level interrupt (see Optional Feature).

Behaviour:
- Reset (rst_i=0 at a clock edge): sync regs, sample reg, debounced reg deb=0; chg=0; prescaler=0; stable count=0; ctrl.en=1; ctrl.ie=0; state=S_WAIT; rdata=0; irq=0. Reset mid-debounce discards all progress.
- Input path: 2-flop synchronizer on data_sw (sw_s); 2-cycle latency.
- Prescaler: counts 0..PRESC_DIV-1 while en=1. Tick pulses one cycle at wrap. When en=0 it is held at 0, the stable count is cleared and deb is frozen.
- FSM states: S_WAIT, S_CMP, S_COMMIT.
  - S_WAIT: on tick, latch smp=sw_s and go to S_CMP.
  - S_CMP: if smp==last, cnt=min(cnt+1,DEB_SAMPLES); else cnt=1 and last=smp. Go to S_COMMIT if the new cnt==DEB_SAMPLES and last!=deb; otherwise go to S_WAIT.
  - S_COMMIT: deb<=last, chg<=chg|(deb^last), cnt stays saturated, go to S_WAIT.
  - A stable vector commits exactly once. No further commit occurs until the vector differs from deb for DEB_SAMPLES ticks.
- Worst-case latency from a switch edge to deb update: 2 + DEB_SAMPLES*PRESC_DIV + 2 cycles.
- Register map (rdata updates on the edge after addr is presented; 1-cycle read latency):
  - BASE_ADDR: read {{8{deb[23]}},deb}, sign-extended.
  - BASE_ADDR+4: read {8'b0,chg}. A write clears chg bits where wdata[23:0]=1 (W1C).
  - BASE_ADDR+8: read {30'b0,ie,en}. A write sets en=wdata[0] and ie=wdata[1].
  - Any other addr: rdata holds its previous value. Writes are ignored.
- Simultaneous W1C and S_COMMIT on the same chg bit: set wins, so the bit reads 1.
- Clearing en mid-FSM: the FSM returns to S_WAIT next cycle without committing.
- Writes to the data register are ignored.

Optional Feature:
SWITCH_IRQ_EN
- Defined: irq is registered and equals ie & (|chg). It deasserts one cycle after W1C clears the last set bit or ie is written 0. It reasserts on the cycle after a commit sets chg with ie=1.
- Undefined: irq is tied 0. ctrl bit1 reads 0 and ignores writes. No irq logic is synthesized.

Test Plan:
(PRESC_DIV=4, DEB_SAMPLES=3)
- Reset: hold rst_i=0 for 3 cycles with data_sw=24'hFFFFFF, release, read 0x070 immediately → rdata=32'h0; 0x078 → 32'h1; irq=0.
- Steady input: data_sw=24'h800001 held; within 18 cycles read 0x070 → 32'hFF800001; read 0x074 → 32'h00800001.
- Glitch rejection: from deb=0, pulse data_sw[0]=1 for 5 cycles then 0 → 0x070 stays 32'h0 for 40 cycles; chg stays 0.
- W1C plus IRQ (SWITCH_IRQ_EN defined): write 0x078=32'h3, commit 24'h000010 → irq=1; write 0x074=32'h10 → irq=0 next cycle; 0x074 reads 32'h0.
- Set-wins race: align a W1C of bit4 with the S_COMMIT cycle that sets bit4 → 0x074 reads 32'h10.
- Disable: write 0x078=32'h0, change data_sw to 24'h00FF00 for 40 cycles → 0x070 unchanged. Write 0x078=32'h1 → deb=24'h00FF00 within 18 cycles.
